warp_scoreboard: RTL and testbench
==================================

Name: warp_scoreboard

Overview:
- Per-warp dependency tracker that produces the `scoreboard` blocked mask consumed by the downstream warp scheduler.
- Holds one staged next-instruction descriptor per warp, written by decode.
- Records outstanding destination-register writes per warp in a small slot array: allocated on issue, released on writeback.
- A warp is blocked whenever its staged instruction has a RAW or WAW hazard, has no free slot, or nothing is staged.

Parameters:
WARP_CNT, 64, number of resident warps (matches the scheduler)
REG_W, 6, architectural register index width
SLOTS, 4, outstanding-write slots per warp
IDX_W, $clog2(WARP_CNT), warp index width

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
dec_valid  in  1  decode writes a staged descriptor this cycle
dec_warp  in  IDX_W  target warp
dec_src0  in  REG_W  source register 0
dec_src1  in  REG_W  source register 1
dec_dst  in  REG_W  destination register
dec_dst_valid  in  1  instruction writes dec_dst
issue_valid  in  1  scheduler issued a warp (scheduler valid)
issue_warp  in  IDX_W  issued warp (scheduler sel_idx)
wb_valid  in  1  writeback completes this cycle
wb_warp  in  IDX_W  writeback warp
wb_dst  in  REG_W  register written back
scoreboard  out  WARP_CNT  1 => warp blocked
staged  out  WARP_CNT  1 => warp holds a staged descriptor (decode back-pressure)
err  out  1  sticky protocol-error flag

Behaviour:
- Reset is synchronous; it is sampled on the rising clk edge when rst_n=0.
- Reset clears all staged-valid bits, all slot-valid bits and err. Outputs after reset: scoreboard = all ones (nothing staged), staged = 0, err = 0.
- Reset asserted mid-operation discards all pending slots; writebacks arriving after reset with no matching slot raise err.
- State is fully registered. scoreboard and staged are combinational decodes of that state only, never of same-cycle inputs. Every event is therefore visible on the outputs in the cycle after the clock edge that captures it.
- Hazard rule, evaluated per warp w; blocked[w] = 1 if any of:
  - staged[w] = 0
  - any valid slot dst equals src0 or src1 (RAW)
  - dst_valid and any valid slot dst equals the staged dst (WAW)
  - dst_valid and all SLOTS slots are valid
  Otherwise blocked[w] = 0.
- Intra-cycle processing order, same edge:
  1. Writeback: clear the single slot of wb_warp whose dst equals wb_dst. If no slot matches, set err.
  2. Issue, evaluated against post-writeback state:
     - clear staged[issue_warp];
     - if dst_valid, allocate the lowest-index free slot with the staged dst.
     - A writeback to the same warp in the same cycle may free the slot that the issue then uses.
     - Issue of a warp that is blocked in the post-writeback state, or that has no staged descriptor: no allocation, staged cleared, err set.
  3. Decode: load the descriptor into dec_warp and set staged.
     - Decode to a warp that is staged and not issued this cycle: overwrite and set err.
     - Decode and issue to the same warp in the same cycle: issue consumes the old descriptor, decode installs the new one, no error.
- WAW blocking guarantees at most one valid slot per (warp, register), so writeback matching is unambiguous.
- err is cleared only by reset.
- No arithmetic beyond equality compares; register indices are compared at full REG_W width.

Decomposition:
- Shared package `warp_pkg`:
  - constants WARP_CNT, REG_W, SLOTS;
  - typedef `warp_idx_t`;
  - struct `staged_inst_t` {src0, src1, dst, dst_valid};
  - struct `sb_slot_t` {valid, dst}.
- One sub-module, `warp_sb_entry`, instantiated WARP_CNT times. Each instance holds one warp's staged descriptor and slot array, and computes that warp's blocked bit plus match/free-slot logic.
- The top level decodes the warp indices into per-entry enables and ORs the per-entry error pulses into err.

Test Plan:
- Reset then idle -> scoreboard = all ones, staged = 0, err = 0.
- Decode warp 3 (src0=1, src1=2, dst=5, dst_valid=1) -> next cycle staged[3]=1 and scoreboard[3]=0. Issue warp 3 -> slot dst=5 allocated and scoreboard[3]=1. Decode warp 3 with src0=5 -> scoreboard[3] stays 1 (RAW). wb warp 3 dst=5 -> scoreboard[3]=0 the following cycle.
- Warp 7: issue 4 distinct dsts (10, 11, 12, 13) without writeback, then stage dst=14 -> scoreboard[7]=1 (slots full). wb dst=12 in the same cycle as issuing warp 7 -> issue succeeds and uses the freed slot 2, err=0.
- Same cycle: issue warp 9 and decode warp 9 -> the old descriptor is consumed, the new one is staged, staged[9] remains 1, err=0.
- Protocol errors, each checked from reset: wb warp 2 dst=4 with no pending slot -> err=1. Issue of an unstaged warp 0 -> err=1. Decode to an already-staged, unissued warp -> err=1. In each case err stays 1 until rst_n=0.
- Reset asserted with slots pending on warps 1 and 63 -> all slots cleared, scoreboard = all ones the next cycle; a later wb to warp 63 -> err=1.

Source files
------------

// File: rtl/warp_pkg.sv
// warp_pkg: shared constants, types and hazard helper for the warp scoreboard
package warp_pkg;
  localparam int WARP_CNT = 64;
  localparam int REG_W = 6;
  localparam int SLOTS = 4;
  localparam int IDX_W = $clog2(WARP_CNT);
  typedef logic [IDX_W-1:0] warp_idx_t;
  typedef logic [REG_W-1:0] reg_t;
  typedef struct packed {
    reg_t src0;
    reg_t src1;
    reg_t dst;
    logic dst_valid;
  } staged_inst_t;
  typedef struct packed {
    logic valid;
    reg_t dst;
  } sb_slot_t;
  typedef sb_slot_t [SLOTS-1:0] sb_slots_t;
  function automatic logic is_blocked(logic stg, staged_inst_t i, sb_slots_t s);
    logic b;
    logic full;
    b = !stg;
    full = 1'b1;
    for (int k = 0; k < SLOTS; k++) begin
      b = b | (s[k].valid && (s[k].dst == i.src0 || s[k].dst == i.src1 ||
                              (i.dst_valid && s[k].dst == i.dst)));
      full = full & s[k].valid;
    end
    return b | (i.dst_valid & full);
  endfunction
endpackage

// File: rtl/warp_sb_entry.sv
// warp_sb_entry: one warp's staged descriptor, outstanding-write slots and blocked bit
module warp_sb_entry
  import warp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         dec_en,
  input  staged_inst_t dec_inst,
  input  logic         issue_en,
  input  logic         wb_en,
  input  reg_t         wb_dst,
  output logic         blocked,
  output logic         staged,
  output logic         err_pulse
);
  staged_inst_t inst_q;
  logic staged_q;
  sb_slots_t slots_q, slots_wb, slots_d;
  logic [SLOTS-1:0] wb_hit;
  logic blocked_wb, iss_ok, found;
  // writeback release, then issue allocation against the post-writeback slots
  always_comb begin
    slots_wb = slots_q;
    wb_hit = '0;
    for (int k = 0; k < SLOTS; k++) begin
      wb_hit[k] = wb_en && slots_q[k].valid && slots_q[k].dst == wb_dst;
      slots_wb[k].valid = slots_q[k].valid & ~wb_hit[k];
    end
    blocked_wb = is_blocked(staged_q, inst_q, slots_wb);
    iss_ok = issue_en & ~blocked_wb;
    slots_d = slots_wb;
    found = 1'b0;
    for (int k = 0; k < SLOTS; k++) begin
      if (iss_ok && inst_q.dst_valid && !found && !slots_wb[k].valid) begin
        slots_d[k].valid = 1'b1;
        slots_d[k].dst = inst_q.dst;
        found = 1'b1;
      end
    end
    err_pulse = (wb_en && wb_hit == '0) || (issue_en && blocked_wb) ||
                (dec_en && staged_q && !issue_en);
  end
  // state update: issue consumes the old descriptor before decode installs a new one
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      staged_q <= 1'b0;
      slots_q <= '0;
      inst_q <= '0;
    end else begin
      slots_q <= slots_d;
      staged_q <= dec_en | (staged_q & ~issue_en);
      if (dec_en) inst_q <= dec_inst;
    end
  end
  assign blocked = is_blocked(staged_q, inst_q, slots_q);
  assign staged = staged_q;
endmodule

// File: rtl/warp_scoreboard.sv
// warp_scoreboard: per-warp RAW/WAW dependency tracker producing the scheduler's blocked mask
module warp_scoreboard
  import warp_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                dec_valid,
  input  logic [IDX_W-1:0]    dec_warp,
  input  logic [REG_W-1:0]    dec_src0,
  input  logic [REG_W-1:0]    dec_src1,
  input  logic [REG_W-1:0]    dec_dst,
  input  logic                dec_dst_valid,
  input  logic                issue_valid,
  input  logic [IDX_W-1:0]    issue_warp,
  input  logic                wb_valid,
  input  logic [IDX_W-1:0]    wb_warp,
  input  logic [REG_W-1:0]    wb_dst,
  output logic [WARP_CNT-1:0] scoreboard,
  output logic [WARP_CNT-1:0] staged,
  output logic                err
);
  staged_inst_t dec_inst;
  logic [WARP_CNT-1:0] err_pulse;
  assign dec_inst = '{dec_src0, dec_src1, dec_dst, dec_dst_valid};
  for (genvar g = 0; g < WARP_CNT; g++) begin : g_entry
    warp_sb_entry u_entry (
      .clk      (clk),
      .rst_n    (rst_n),
      .dec_en   (dec_valid && dec_warp == IDX_W'(g)),
      .dec_inst (dec_inst),
      .issue_en (issue_valid && issue_warp == IDX_W'(g)),
      .wb_en    (wb_valid && wb_warp == IDX_W'(g)),
      .wb_dst   (wb_dst),
      .blocked  (scoreboard[g]),
      .staged   (staged[g]),
      .err_pulse(err_pulse[g])
    );
  end
  // sticky protocol error, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) err <= 1'b0;
    else err <= err | (|err_pulse);
  end
endmodule

// File: tb/tb_warp_scoreboard.sv
// tb_warp_scoreboard: directed stimulus with a queued-expectation scoreboard and negedge monitor
module tb_warp_scoreboard;
  import warp_pkg::*;
  logic clk = 0, rst_n = 0;
  logic dec_valid = 0, dec_dst_valid = 0, issue_valid = 0, wb_valid = 0;
  logic [IDX_W-1:0] dec_warp = 0, issue_warp = 0, wb_warp = 0;
  logic [REG_W-1:0] dec_src0 = 0, dec_src1 = 0, dec_dst = 0, wb_dst = 0;
  logic [WARP_CNT-1:0] scoreboard, staged;
  logic err;
  typedef struct {
    string name;
    logic [63:0] sb_m, sb_e, st_m, st_e;
    logic err_e;
  } exp_t;
  exp_t q[$];
  int checks = 0, fails = 0;

  warp_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_warp(dec_warp), .dec_src0(dec_src0), .dec_src1(dec_src1),
    .dec_dst(dec_dst), .dec_dst_valid(dec_dst_valid),
    .issue_valid(issue_valid), .issue_warp(issue_warp),
    .wb_valid(wb_valid), .wb_warp(wb_warp), .wb_dst(wb_dst),
    .scoreboard(scoreboard), .staged(staged), .err(err)
  );

  always #5 clk = ~clk;

  // monitor: pops expectations pushed this cycle and compares at the falling edge
  always @(negedge clk) begin
    while (q.size() > 0) begin
      automatic exp_t e = q.pop_front();
      checks += 3;
      if ((scoreboard & e.sb_m) !== (e.sb_e & e.sb_m)) begin
        fails++;
        $display("FAIL %s scoreboard: got %h want %h (mask %h)", e.name, scoreboard & e.sb_m, e.sb_e & e.sb_m, e.sb_m);
      end
      if ((staged & e.st_m) !== (e.st_e & e.st_m)) begin
        fails++;
        $display("FAIL %s staged: got %h want %h (mask %h)", e.name, staged & e.st_m, e.st_e & e.st_m, e.st_m);
      end
      if (err !== e.err_e) begin
        fails++;
        $display("FAIL %s err: got %b want %b", e.name, err, e.err_e);
      end
    end
  end

  function automatic logic [63:0] bit_of(int w);
    logic [63:0] m;
    m = '0;
    m[w] = 1'b1;
    return m;
  endfunction

  task automatic expect_bits(string name, int w, logic sb, logic st, logic er);
    q.push_back('{name, bit_of(w), sb ? bit_of(w) : 64'd0, bit_of(w), st ? bit_of(w) : 64'd0, er});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    dec_valid = 0; issue_valid = 0; wb_valid = 0;
  endtask

  task automatic do_reset();
    rst_n = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic dec(int w, int s0, int s1, int d, logic dv);
    dec_valid = 1; dec_warp = IDX_W'(w); dec_src0 = REG_W'(s0); dec_src1 = REG_W'(s1);
    dec_dst = REG_W'(d); dec_dst_valid = dv;
  endtask

  task automatic iss(int w);
    issue_valid = 1; issue_warp = IDX_W'(w);
  endtask

  task automatic wb(int w, int d);
    wb_valid = 1; wb_warp = IDX_W'(w); wb_dst = REG_W'(d);
  endtask

  initial begin
    do_reset();
    q.push_back('{"reset", '1, '1, '1, 64'd0, 1'b0});
    tick();
    q.push_back('{"idle", '1, '1, '1, 64'd0, 1'b0});
    // RAW / writeback on warp 3
    dec(3, 1, 2, 5, 1); tick(); expect_bits("w3_staged", 3, 0, 1, 0);
    iss(3); tick(); expect_bits("w3_issued", 3, 1, 0, 0);
    dec(3, 5, 2, 6, 1); tick(); expect_bits("w3_raw", 3, 1, 1, 0);
    wb(3, 5); tick(); expect_bits("w3_wb", 3, 0, 1, 0);
    // fill warp 7's slots
    for (int d = 10; d < 14; d++) begin
      dec(7, 0, 1, d, 1); tick();
      iss(7); tick();
    end
    expect_bits("w7_four_issued", 7, 1, 0, 0);
    dec(7, 0, 1, 14, 1); tick(); expect_bits("w7_full", 7, 1, 1, 0);
    wb(7, 12); iss(7); tick(); expect_bits("w7_wb_issue", 7, 1, 0, 0);
    dec(7, 14, 0, 20, 1); tick(); expect_bits("w7_raw14", 7, 1, 1, 0);
    wb(7, 14); tick(); expect_bits("w7_wb14", 7, 0, 1, 0);
    // same-cycle issue and decode on warp 9
    dec(9, 0, 0, 30, 1); tick(); expect_bits("w9_staged", 9, 0, 1, 0);
    dec(9, 30, 0, 31, 1); iss(9); tick(); expect_bits("w9_iss_dec", 9, 1, 1, 0);
    // stray writeback
    do_reset();
    wb(2, 4); tick(); expect_bits("stray_wb", 2, 1, 0, 1);
    tick(); tick(); expect_bits("stray_wb_sticky", 2, 1, 0, 1);
    do_reset(); expect_bits("err_cleared", 2, 1, 0, 0);
    // issue of unstaged warp 0
    iss(0); tick(); expect_bits("unstaged_issue", 0, 1, 0, 1);
    tick(); expect_bits("unstaged_sticky", 0, 1, 0, 1);
    // decode over a staged, unissued warp
    do_reset();
    dec(5, 0, 1, 2, 1); tick(); expect_bits("w5_staged", 5, 0, 1, 0);
    dec(5, 3, 4, 6, 1); tick(); expect_bits("w5_overwrite", 5, 0, 1, 1);
    tick(); expect_bits("w5_sticky", 5, 0, 1, 1);
    // reset with pending slots on warps 1 and 63
    do_reset();
    dec(1, 0, 0, 40, 1); tick(); iss(1); tick();
    dec(63, 0, 0, 41, 1); tick(); iss(63); tick();
    dec(63, 41, 0, 42, 1); tick(); expect_bits("w63_raw", 63, 1, 1, 0);
    do_reset();
    q.push_back('{"reset_pending", '1, '1, '1, 64'd0, 1'b0});
    wb(63, 41); tick(); expect_bits("wb_after_reset", 63, 1, 0, 1);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
